// File: rtl/framebuffer_writer.sv
// Pixel-stream to framebuffer write converter with a small pixel FIFO and
// vsync-aligned buffer swap at frame boundaries.
module framebuffer_writer #(
  parameter int unsigned H_RES      = 640,
  parameter int unsigned V_RES      = 480,
  parameter int unsigned H_BITS     = 10,
  parameter int unsigned V_BITS     = 9,
  parameter int unsigned ADDR_LEN   = 19,
  parameter int unsigned COLOR_BITS = 4,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic [H_BITS-1:0]     hcount_in,
  input  logic [V_BITS-1:0]     vcount_in,
  input  logic [COLOR_BITS-1:0] color_in,
  input  logic                  valid_in,
  input  logic                  new_frame_in,
  output logic                  ready_out,
  input  logic                  vsync_in,
  output logic                  write_enable_out,
  output logic [ADDR_LEN-1:0]   write_addr_out,
  output logic [COLOR_BITS-1:0] write_data_out,
  output logic                  swap_buffers_out,
  output logic [15:0]           frame_count_out,
  output logic                  overflow_out,
  output logic                  range_err_out
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_DRAIN      = 2'd0,
    ST_WAIT_VSYNC = 2'd1,
    ST_SWAP       = 2'd2
  } state_e;

  state_e                state_q;
  logic                  sof_mem   [FIFO_DEPTH];
  logic [ADDR_LEN-1:0]   addr_mem  [FIFO_DEPTH];
  logic [COLOR_BITS-1:0] color_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  ready_q, dirty_q;
  logic [2:0]            vsync_q;
  logic                  we_q, swap_q, overflow_q, range_err_q;
  logic [ADDR_LEN-1:0]   waddr_q;
  logic [COLOR_BITS-1:0] wdata_q;
  logic [15:0]           frame_count_q;

  logic                  in_range_c, push_c, pop_c, empty_c, head_sof_c, vsync_rise_c;
  logic [ADDR_LEN-1:0]   pix_addr_c;

  assign in_range_c   = (32'(hcount_in) < H_RES) && (32'(vcount_in) < V_RES);
  assign pix_addr_c   = ADDR_LEN'(vcount_in) * ADDR_LEN'(H_RES) + ADDR_LEN'(hcount_in);
  assign push_c       = valid_in && ready_q && in_range_c;
  assign empty_c      = (count_q == '0);
  assign head_sof_c   = sof_mem[rd_ptr_q];
  assign vsync_rise_c = vsync_q[1] && !vsync_q[2];
  assign count_d      = count_q + CNT_W'(push_c) - CNT_W'(pop_c);

  // A dirty frame's first pixel stays at the head until the swap; the SWAP
  // cycle itself pops it so the new frame's first write follows immediately.
  always_comb begin
    pop_c = 1'b0;
    case (state_q)
      ST_DRAIN: pop_c = !empty_c && !(head_sof_c && dirty_q);
      ST_SWAP:  pop_c = !empty_c;
      default:  pop_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (push_c) begin
      sof_mem[wr_ptr_q]   <= new_frame_in;
      addr_mem[wr_ptr_q]  <= pix_addr_c;
      color_mem[wr_ptr_q] <= color_in;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q       <= ST_DRAIN;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      ready_q       <= 1'b0;
      dirty_q       <= 1'b0;
      vsync_q       <= '0;
      we_q          <= 1'b0;
      waddr_q       <= '0;
      wdata_q       <= '0;
      swap_q        <= 1'b0;
      frame_count_q <= '0;
      overflow_q    <= 1'b0;
      range_err_q   <= 1'b0;
    end else begin
      vsync_q  <= {vsync_q[1:0], vsync_in};
      count_q  <= count_d;
      ready_q  <= (32'(count_d) < FIFO_DEPTH);
      we_q     <= pop_c;
      swap_q   <= 1'b0;
      if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        waddr_q  <= addr_mem[rd_ptr_q];
        wdata_q  <= color_mem[rd_ptr_q];
      end
      if (valid_in && !ready_q) overflow_q <= 1'b1;
      if (valid_in && ready_q && !in_range_c) range_err_q <= 1'b1;

      case (state_q)
        ST_DRAIN: begin
          if (pop_c) dirty_q <= 1'b1;
          if (!empty_c && head_sof_c && dirty_q) state_q <= ST_WAIT_VSYNC;
        end
        ST_WAIT_VSYNC: begin
          if (vsync_rise_c) begin
            state_q       <= ST_SWAP;
            swap_q        <= 1'b1;
            frame_count_q <= frame_count_q + 16'd1;
            dirty_q       <= 1'b0;
          end
        end
        ST_SWAP: begin
          if (pop_c) dirty_q <= 1'b1;
          state_q <= ST_DRAIN;
        end
        default: state_q <= ST_DRAIN;
      endcase
    end
  end

  assign ready_out        = ready_q;
  assign write_enable_out = we_q;
  assign write_addr_out   = waddr_q;
  assign write_data_out   = wdata_q;
  assign swap_buffers_out = swap_q;
  assign frame_count_out  = frame_count_q;
  assign overflow_out     = overflow_q;
  assign range_err_out    = range_err_q;

endmodule

// File: tb/tb_framebuffer_writer.sv
// Directed cycle tables plus a scoreboarded random-frame run for framebuffer_writer.
module tb_framebuffer_writer;

  typedef struct {
    logic        valid;
    logic        sof;
    logic [9:0]  h;
    logic [8:0]  v;
    logic [3:0]  c;
    logic        vs;
    logic        we;
    logic [18:0] addr;
    logic [3:0]  data;
    logic        swap;
    logic        ready;
    logic [15:0] fc;
  } vec_t;

  typedef struct {
    logic        sof;
    logic [18:0] addr;
    logic [3:0]  data;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  hcount;
  logic [8:0]  vcount;
  logic [3:0]  color;
  logic        valid, new_frame;
  logic        vsync, vsync_man, vsync_rand, vs_auto;
  logic        ready, we, swap, overflow, range_err;
  logic [18:0] waddr;
  logic [3:0]  wdata;
  logic [15:0] fcount;

  int   n_vec = 0;
  int   n_err = 0;
  int   swaps = 0;
  logic sb_en = 1'b0;
  vec_t tbl[$];
  sb_t  exp_q[$];

  assign vsync = vs_auto ? vsync_rand : vsync_man;

  always #5 clk = ~clk;

  framebuffer_writer dut (
    .clk_in(clk), .rst_n_in(rst_n),
    .hcount_in(hcount), .vcount_in(vcount), .color_in(color),
    .valid_in(valid), .new_frame_in(new_frame), .ready_out(ready),
    .vsync_in(vsync),
    .write_enable_out(we), .write_addr_out(waddr), .write_data_out(wdata),
    .swap_buffers_out(swap), .frame_count_out(fcount),
    .overflow_out(overflow), .range_err_out(range_err)
  );

  initial begin
    vsync_rand = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (vs_auto) begin
        vsync_rand = ~vsync_rand;
        repeat ($urandom_range(3, 40)) @(posedge clk);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input int vld, input int sf, input int h, input int v, input int c,
                              input int vs, input int ewe, input int eaddr, input int edata,
                              input int eswap, input int erdy, input int efc);
    vec_t r;
    r.valid = 1'(vld);  r.sof = 1'(sf);   r.h = 10'(h);      r.v = 9'(v);
    r.c = 4'(c);        r.vs = 1'(vs);    r.we = 1'(ewe);    r.addr = 19'(eaddr);
    r.data = 4'(edata); r.swap = 1'(eswap); r.ready = 1'(erdy); r.fc = 16'(efc);
    return r;
  endfunction

  // One clock step; in scoreboard mode every write and swap is checked here.
  task automatic tick();
    sb_t e;
    @(posedge clk); #1;
    if (sb_en) begin
      if (swap) begin
        swaps++;
        chk("sb_swap_no_write", 32'(we), 32'd0);
        chk("sb_swap_head_sof", 32'(exp_q.size() > 0 && exp_q[0].sof), 32'd1);
      end
      if (we) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL sb_unexpected_write: got addr %0d expected no write", waddr);
        end else begin
          e = exp_q.pop_front();
          chk("sb_addr", 32'(waddr), 32'(e.addr));
          chk("sb_data", 32'(wdata), 32'(e.data));
        end
      end
    end
  endtask

  task automatic run_tbl(input string tag);
    foreach (tbl[i]) begin
      valid = tbl[i].valid; new_frame = tbl[i].sof; hcount = tbl[i].h;
      vcount = tbl[i].v;    color = tbl[i].c;       vsync_man = tbl[i].vs;
      tick();
      chk($sformatf("%s[%0d].we", tag, i), 32'(we), 32'(tbl[i].we));
      if (tbl[i].we) begin
        chk($sformatf("%s[%0d].addr", tag, i), 32'(waddr), 32'(tbl[i].addr));
        chk($sformatf("%s[%0d].data", tag, i), 32'(wdata), 32'(tbl[i].data));
      end
      chk($sformatf("%s[%0d].swap", tag, i), 32'(swap), 32'(tbl[i].swap));
      chk($sformatf("%s[%0d].ready", tag, i), 32'(ready), 32'(tbl[i].ready));
      chk($sformatf("%s[%0d].fc", tag, i), 32'(fcount), 32'(tbl[i].fc));
    end
    valid = 1'b0; new_frame = 1'b0;
    tbl.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".ready"}, 32'(ready), 32'd0);
    chk({tag, ".we"}, 32'(we), 32'd0);
    chk({tag, ".addr"}, 32'(waddr), 32'd0);
    chk({tag, ".data"}, 32'(wdata), 32'd0);
    chk({tag, ".swap"}, 32'(swap), 32'd0);
    chk({tag, ".fc"}, 32'(fcount), 32'd0);
    chk({tag, ".ovf"}, 32'(overflow), 32'd0);
    chk({tag, ".rerr"}, 32'(range_err), 32'd0);
  endtask

  initial begin
    int nf, npix, guard, hh, vv;
    sb_t e;
    rst_n = 1'b0; valid = 1'b0; new_frame = 1'b0; hcount = '0; vcount = '0; color = '0;
    vsync_man = 1'b0; vs_auto = 1'b0;

    // Reset state and ready rising one edge after release
    repeat (3) @(posedge clk);
    #3;
    chk_all_zero("reset");
    #3 rst_n = 1'b1;
    chk("rel.ready_before_edge", 32'(ready), 32'd0);
    tick();
    chk("rel.ready_after_edge", 32'(ready), 32'd1);

    // Frame 0: four pixels, 2-cycle latency, no swap
    tbl.push_back(mk(1,1,  0,0,1, 0, 0,  0,0, 0,1,0));
    tbl.push_back(mk(1,0,  1,0,2, 0, 1,  0,1, 0,1,0));
    tbl.push_back(mk(1,0,639,0,3, 0, 1,  1,2, 0,1,0));
    tbl.push_back(mk(1,0,  0,1,4, 0, 1,639,3, 0,1,0));
    tbl.push_back(mk(0,0,  0,0,0, 0, 1,640,4, 0,1,0));
    tbl.push_back(mk(0,0,  0,0,0, 0, 0,  0,0, 0,1,0));
    // Dirty-frame sof at (5,2) then 7 more: FIFO fills, ready drops after 8 accepts
    tbl.push_back(mk(1,1,  5,2,5, 0, 0,  0,0, 0,1,0));
    for (int i = 0; i < 7; i++)
      tbl.push_back(mk(1,0,6+i,2,6+i, 0, 0,0,0, 0,(i == 6) ? 0 : 1, 0));
    run_tbl("frame0");

    // Long vsync-low wait with an overflow attempt in the middle
    for (int i = 0; i < 50; i++) begin
      valid = (i == 10); hcount = 10'd100; vcount = 9'd3; color = 4'd15;
      tick();
      if (i == 0 || i == 25 || i == 49) begin
        chk($sformatf("stall[%0d].we", i), 32'(we), 32'd0);
        chk($sformatf("stall[%0d].ready", i), 32'(ready), 32'd0);
        chk($sformatf("stall[%0d].swap", i), 32'(swap), 32'd0);
      end
    end
    valid = 1'b0;
    chk("overflow_set", 32'(overflow), 32'd1);

    // Rising vsync: swap 3 edges later, then 1285..1292 drain
    tbl.push_back(mk(0,0,0,0,0, 1, 0,0,0, 0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 1, 0,0,0, 0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 1, 0,0,0, 1,0,1));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(0,0,0,0,0, 1, 1,1285+i,5+i, 0,1,1));
    tbl.push_back(mk(0,0,0,0,0, 1, 0,0,0, 0,1,1));
    run_tbl("swap");

    // Out-of-range pixels (first carries a lost sof), then (0,0)
    tbl.push_back(mk(1,1,640,  0,1, 1, 0,0,0, 0,1,1));
    tbl.push_back(mk(1,0,  0,480,2, 1, 0,0,0, 0,1,1));
    tbl.push_back(mk(1,0,  0,  0,3, 1, 0,0,0, 0,1,1));
    tbl.push_back(mk(0,0,  0,  0,0, 1, 1,0,3, 0,1,1));
    tbl.push_back(mk(0,0,  0,  0,0, 0, 0,0,0, 0,1,1));
    run_tbl("range");
    chk("range_err_set", 32'(range_err), 32'd1);
    chk("overflow_sticky", 32'(overflow), 32'd1);

    // Reset in WAIT_VSYNC with a full FIFO
    for (int i = 0; i < 8; i++) begin
      valid = 1'b1; new_frame = (i == 0); hcount = 10'(20 + i); vcount = 9'd7; color = 4'(i);
      tick();
    end
    valid = 1'b0; new_frame = 1'b0;
    repeat (3) tick();
    chk("wait_full.ready", 32'(ready), 32'd0);
    chk("wait_full.we", 32'(we), 32'd0);
    #3 rst_n = 1'b0;
    #1 chk_all_zero("midreset");
    vsync_man = 1'b1;
    #2 rst_n = 1'b1;
    chk("rel2.ready_before_edge", 32'(ready), 32'd0);
    tick();
    chk("rel2.ready_after_edge", 32'(ready), 32'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (swap || we) begin
        n_vec++; n_err++;
        $display("FAIL post_reset_activity: got swap=%0d we=%0d expected 0", swap, we);
      end
    end
    chk("post_reset.fc", 32'(fcount), 32'd0);

    // Random frames with random vsync timing, scoreboarded
    vs_auto = 1'b1;
    sb_en   = 1'b1;
    nf      = 5;
    for (int f = 0; f < nf; f++) begin
      npix = $urandom_range(4, 12);
      for (int p = 0; p < npix; p++) begin
        guard = 0;
        while (!ready && guard < 500) begin tick(); guard++; end
        if (guard >= 500) begin
          n_vec++; n_err++;
          $display("FAIL rnd_ready_timeout: got ready=0 expected 1 within 500 cycles");
        end
        hh = $urandom_range(0, 639);
        vv = $urandom_range(0, 479);
        valid = 1'b1; new_frame = (p == 0); hcount = 10'(hh); vcount = 9'(vv);
        color = 4'($urandom_range(0, 15));
        e.sof = (p == 0); e.addr = 19'(vv * 640 + hh); e.data = color;
        exp_q.push_back(e);
        tick();
        valid = 1'b0; new_frame = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
      end
    end
    guard = 0;
    while (exp_q.size() > 0 && guard < 3000) begin tick(); guard++; end
    chk("rnd_drained_left", 32'(exp_q.size()), 32'd0);
    repeat (5) tick();
    chk("rnd_swaps", 32'(swaps), 32'(nf - 1));
    chk("rnd_fc", 32'(fcount), 32'(nf - 1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
